// File: rtl/spi_channel_scheduler_if.sv
// Bus bundle between the SPI slave-side shifter/channels and the channel scheduler.
interface spi_channel_scheduler_if #(
  parameter int unsigned NCH = 16,
  parameter int unsigned DW  = 28
);
  logic [DW-1:0]     status_in;
  logic [NCH-1:0]    tx_valid;
  logic [NCH*DW-1:0] tx_data;
  logic [NCH-1:0]    tx_ready;
  logic              frame_load;
  logic [31:0]       frame_word;
  logic              frame_done;
  logic              frame_ok;
  logic              rx_valid;
  logic [31:0]       rx_word;
  logic [NCH-1:0]    rx_strobe;
  logic [DW-1:0]     rx_data;

  modport master (
    output status_in, tx_valid, tx_data, frame_load, frame_done, frame_ok, rx_valid, rx_word,
    input  tx_ready, frame_word, rx_strobe, rx_data
  );

  modport slave (
    input  status_in, tx_valid, tx_data, frame_load, frame_done, frame_ok, rx_valid, rx_word,
    output tx_ready, frame_word, rx_strobe, rx_data
  );
endinterface

// File: rtl/spi_channel_scheduler.sv
// Round-robin MISO frame scheduler and MOSI frame demux for the channelised SPI slave link.
// Optional SPI_SCHED_RETRY_EN: keep the in-flight word and resend it after an aborted frame.
module spi_channel_scheduler #(
  parameter int unsigned NCH = 16,
  parameter int unsigned DW  = 28
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_channel_scheduler_if.slave bus
);
  localparam int unsigned IW = 4;
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          stg_vld;
  logic [IW-1:0] stg_idx;
  logic [DW-1:0] stg_data;
  logic [SW-1:0] rr_ptr;
  logic          arb_en;
  logic          gnt_found;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] next_ptr;
  logic [DW-1:0] gnt_data;
  int unsigned   cand;
  logic [15:0]   rx_dec;

`ifdef SPI_SCHED_RETRY_EN
  logic          inflight_vld;
  logic [IW-1:0] inf_idx;
  logic [DW-1:0] inf_data;

  assign arb_en = !stg_vld && !bus.frame_load && !inflight_vld;
`else
  logic unused_done;

  assign unused_done = bus.frame_done ^ bus.frame_ok;
  assign arb_en      = !stg_vld && !bus.frame_load;
`endif

  // Search rr_ptr, rr_ptr+1, ... wrapping NCH-1 -> 1; channel 0 is never a candidate
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NCH - 1; i++) begin
      cand = ((32'(rr_ptr) + i - 1) % (NCH - 1)) + 1;
      if (arb_en && !gnt_found && bus.tx_valid[SW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'(cand);
      end
    end
  end

  assign gnt_data      = bus.tx_data[32'(gnt_idx) * DW +: DW];
  assign next_ptr      = (gnt_idx == SW'(NCH - 1)) ? SW'(1) : gnt_idx + SW'(1);
  assign bus.tx_ready  = gnt_found ? (NCH'(1) << gnt_idx) : '0;
  assign bus.frame_word = stg_vld ? {stg_idx, stg_data} : {IW'(0), bus.status_in};

  // Staging register: a load always wins over a grant in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld  <= 1'b0;
      stg_idx  <= '0;
      stg_data <= '0;
      rr_ptr   <= SW'(1);
    end else if (bus.frame_load) begin
      stg_vld <= 1'b0;
    end
`ifdef SPI_SCHED_RETRY_EN
    else if (bus.frame_done && !bus.frame_ok && inflight_vld) begin
      stg_vld  <= 1'b1;
      stg_idx  <= inf_idx;
      stg_data <= inf_data;
    end
`endif
    else if (gnt_found) begin
      stg_vld  <= 1'b1;
      stg_idx  <= IW'(gnt_idx);
      stg_data <= gnt_data;
      rr_ptr   <= next_ptr;
    end
  end

`ifdef SPI_SCHED_RETRY_EN
  // A new load implicitly acknowledges any previous in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_vld <= 1'b0;
      inf_idx      <= '0;
      inf_data     <= '0;
    end else if (bus.frame_load) begin
      inflight_vld <= stg_vld;
      if (stg_vld) begin
        inf_idx  <= stg_idx;
        inf_data <= stg_data;
      end
    end else if (bus.frame_done && inflight_vld) begin
      inflight_vld <= 1'b0;
    end
  end
`endif

  // Out-of-range indices decode past the strobe vector and are dropped
  assign rx_dec = 16'(1) << bus.rx_word[31:28];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_strobe <= '0;
      bus.rx_data   <= '0;
    end else begin
      bus.rx_strobe <= bus.rx_valid ? rx_dec[NCH-1:0] : '0;
      if (bus.rx_valid) begin
        bus.rx_data <= bus.rx_word[DW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_spi_channel_scheduler.sv
// Directed scoreboard bench for spi_channel_scheduler (TX arbitration, filler, RX demux, retry, reset).
module tb_spi_channel_scheduler;
  localparam int unsigned NCH = 16;
  localparam int unsigned DW  = 28;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] txq[$];
  logic [43:0] rxq[$];
  logic [31:0] exp_w;
  logic [43:0] exp_rx;

  spi_channel_scheduler_if #(.NCH(NCH), .DW(DW)) bus ();

  spi_channel_scheduler #(.NCH(NCH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] dat(input int k);
    return DW'(32'h0C00000 + k * 32'h10101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_load for one cycle; frame_word must match the scoreboard head while load is high
  task automatic load_check(input string tag);
    bus.frame_load = 1'b1;
    #1;
    exp_w = txq.pop_front();
    chk(tag, bus.frame_word, exp_w);
    chk({tag, "_ready"}, 32'(bus.tx_ready), 32'h0);
    step();
    bus.frame_load = 1'b0;
  endtask

  task automatic rx_check(input string tag);
    exp_rx = rxq.pop_front();
    chk({tag, "_strobe"}, 32'(bus.rx_strobe), 32'(exp_rx[43:28]));
    chk({tag, "_data"}, 32'(bus.rx_data), 32'(exp_rx[27:0]));
  endtask

  initial begin
    int seq[6];
    checks = 0;
    errors = 0;
    seq = '{3, 5, 15, 3, 5, 15};
    rst_n          = 1'b0;
    bus.status_in  = '0;
    bus.tx_valid   = '0;
    bus.frame_load = 1'b0;
    bus.frame_done = 1'b0;
    bus.frame_ok   = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_word    = '0;
    for (int k = 0; k < NCH; k++) bus.tx_data[k*DW +: DW] = dat(k);
    bus.tx_data[2*DW +: DW] = 28'h0000055;

    #2;
    chk("rst_frame_word", bus.frame_word, 32'h0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'h0);
    chk("rst_rx_strobe", 32'(bus.rx_strobe), 32'h0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Idle: status filler
    bus.status_in = 28'h0ABCDEF;
    txq.push_back(32'h00ABCDEF);
    load_check("idle_load");
    #1;
    chk("idle_ready", 32'(bus.tx_ready), 32'h0);

    // Round-robin over channels 3, 5, 15
    bus.tx_valid = 16'h8028;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_grant", 32'(bus.tx_ready), 32'(16'(1) << seq[i]));
      step();
      chk("rr_ready_staged", 32'(bus.tx_ready), 32'h0);
      chk("rr_word_latency", bus.frame_word, {4'(seq[i]), dat(seq[i])});
      txq.push_back({4'(seq[i]), dat(seq[i])});
      load_check("rr_load");
    end

    // Collision: eligible cycle coincides with a filler load
    txq.push_back(32'h00ABCDEF);
    load_check("coll_filler");
    #1;
    chk("coll_grant_next", 32'(bus.tx_ready), 32'h0008);
    step();
    txq.push_back({4'd3, dat(3)});
    load_check("coll_load");
    bus.tx_valid = '0;

    // RX demux, back-to-back
    bus.rx_valid = 1'b1;
    bus.rx_word  = 32'h7123_4567;
    rxq.push_back({16'h0080, 28'h1234567});
    step();
    bus.rx_word = 32'h0ABC_DEF0;
    rxq.push_back({16'h0001, 28'hABCDEF0});
    rx_check("rx_idx7");
    step();
    bus.rx_valid = 1'b0;
    rx_check("rx_idx0");
    step();
    chk("rx_idle", 32'(bus.rx_strobe), 32'h0);

    // Aborted frame of channel 2 (rr_ptr is 4, search wraps to 2)
    bus.tx_valid = 16'h0004;
    #1;
    chk("ab_grant", 32'(bus.tx_ready), 32'h0004);
    step();
    bus.tx_valid = '0;
    txq.push_back(32'h2000_0055);
    load_check("ab_load");
    bus.frame_done = 1'b1;
    bus.frame_ok   = 1'b0;
    #1;
    chk("ab_done_ready", 32'(bus.tx_ready), 32'h0);
    step();
    bus.frame_done = 1'b0;
`ifdef SPI_SCHED_RETRY_EN
    chk("retry_restaged", bus.frame_word, 32'h2000_0055);
    txq.push_back(32'h2000_0055);
    load_check("retry_load");
    bus.frame_done = 1'b1;
    bus.frame_ok   = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("retry_cleared", bus.frame_word, 32'h00ABCDEF);
`else
    chk("noretry_status", bus.frame_word, 32'h00ABCDEF);
    txq.push_back(32'h00ABCDEF);
    load_check("noretry_load");
`endif
    chk("ab_ready_after", 32'(bus.tx_ready), 32'h0);

    // Reset mid-operation with staged word and pending RX strobe (rr_ptr is 3)
    bus.tx_valid = 16'h0040;
    #1;
    chk("mid_grant", 32'(bus.tx_ready), 32'h0040);
    step();
    bus.tx_valid = '0;
    bus.rx_valid = 1'b1;
    bus.rx_word  = 32'h3000_0001;
    rxq.push_back({16'h0008, 28'h0000001});
    chk("mid_staged", bus.frame_word, {4'd6, dat(6)});
    step();
    bus.rx_valid = 1'b0;
    rx_check("mid_rx");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_word", bus.frame_word, 32'h00ABCDEF);
    chk("mid_rst_strobe", 32'(bus.rx_strobe), 32'h0);
    chk("mid_rst_data", 32'(bus.rx_data), 32'h0);
    chk("mid_rst_ready", 32'(bus.tx_ready), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    bus.tx_valid = 16'h4004;
    #1;
    chk("post_rst_ptr", 32'(bus.tx_ready), 32'h0004);
    step();
    bus.tx_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
